// File: rtl/ame_num_approx_arb.sv
// Round-robin sequencer sharing one number-approximation engine among NUM_REQ requesters.
// One request in flight at a time: grant, init pulse, wait for done or timeout, return result.
module ame_num_approx_arb #(
    parameter int NUM_REQ        = 4,
    parameter int COMP_DATA_BITS = 64,
    parameter int TIMEOUT_CYC    = 15
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ*COMP_DATA_BITS-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    input  logic [NUM_REQ-1:0]                  rsp_ready_i,
    output logic [$clog2(COMP_DATA_BITS)-1:0]   rsp_data_o,
    output logic                                rsp_err_o,
    output logic                                eng_init_o,
    output logic [COMP_DATA_BITS-1:0]           eng_data_o,
    input  logic                                eng_done_i,
    input  logic [$clog2(COMP_DATA_BITS)-1:0]   eng_data_i,
    output logic                                busy_o
);

    localparam int RES_W = $clog2(COMP_DATA_BITS);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                     state_q;
    logic [ID_W-1:0]            ptr_q;
    logic [ID_W-1:0]            gnt_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       eng_init_q;
    logic [COMP_DATA_BITS-1:0]  eng_data_q;
    logic [NUM_REQ-1:0]         rsp_valid_q;
    logic [RES_W-1:0]           rsp_data_q;
    logic                       rsp_err_q;

    logic [ID_W-1:0]            gnt_idx_d;
    logic                       gnt_found_d;
    logic                       req_fire;

    // Scan from the highest offset down so the requester closest to ptr_q wins.
    always_comb begin
        gnt_idx_d   = '0;
        gnt_found_d = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_found_d = 1'b1;
                gnt_idx_d   = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign req_fire = (state_q == IDLE) && gnt_found_d;

    always_comb begin
        req_ready_o = '0;
        if (req_fire) begin
            req_ready_o[gnt_idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            eng_init_q  <= 1'b0;
            eng_data_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            eng_init_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        eng_data_q <= req_data_i[int'(gnt_idx_d)*COMP_DATA_BITS +: COMP_DATA_BITS];
                        gnt_q      <= gnt_idx_d;
                        eng_init_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done on the final allowed cycle still counts as success.
                    if (eng_done_i) begin
                        rsp_data_q         <= eng_data_i;
                        rsp_err_q          <= 1'b0;
                        rsp_valid_q[gnt_q] <= 1'b1;
                        state_q            <= RESP;
                    end else if (cnt_q == TO_LAST) begin
                        rsp_data_q         <= '0;
                        rsp_err_q          <= 1'b1;
                        rsp_valid_q[gnt_q] <= 1'b1;
                        state_q            <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i[gnt_q]) begin
                        rsp_valid_q <= '0;
                        ptr_q       <= ID_W'((int'(gnt_q) + 1) % NUM_REQ);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign eng_init_o  = eng_init_q;
    assign eng_data_o  = eng_data_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ame_num_approx_arb.sv
// Scoreboard bench for ame_num_approx_arb: transaction-level model of grant order,
// engine outcome and response timing, with an engine model driven from the same plan.
module tb_ame_num_approx_arb;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int RW = 6;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [RW-1:0]  rsp_data;
    logic           rsp_err;
    logic           eng_init;
    logic [W-1:0]   eng_data_out;
    logic           eng_done;
    logic [RW-1:0]  eng_data_in;
    logic           busy;

    ame_num_approx_arb #(.NUM_REQ(N), .COMP_DATA_BITS(W), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_err_o(rsp_err), .eng_init_o(eng_init), .eng_data_o(eng_data_out),
        .eng_done_i(eng_done), .eng_data_i(eng_data_in), .busy_o(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int id; logic [RW-1:0] data; logic err; longint due; } exp_t;
    typedef struct { logic [W-1:0] opnd; int d; logic [RW-1:0] r; bit spur; longint hs; } op_t;
    typedef struct { int g; longint c; } hs_t;

    exp_t expq[$];
    op_t  opq[$];
    hs_t  hs_log[$];

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    int     m_ptr = 0;
    bit     m_out = 1'b0;
    int     hs_count = 0;
    int     rst_epoch = 0;

    bit         dir_mode = 1'b1;
    logic [N-1:0] dir_mask = '0;
    bit         use_fixed = 1'b0;
    logic [W-1:0] fixed_opnd = '0;
    int         force_d = -1;
    int         force_r = -1;
    bit         rdy_rand = 1'b0;
    int         bp_id = -1;
    int         bp_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired (cycle %0d)", name, cyc);
    endtask

    // Requesters, grant prediction and expected-response generation.
    initial begin : req_drv
        logic [W-1:0] pdata [N];
        bit           pend [N];
        logic [N-1:0] exp_rdy;
        logic [N-1:0] hs;
        int g;
        int d;
        int u;
        op_t  op;
        exp_t e;
        hs_t  h;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                req_valid = '0;
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (dir_mode) begin
                    if (!pend[i] && dir_mask[i]) begin
                        pend[i]  = 1'b1;
                        pdata[i] = use_fixed ? fixed_opnd : {$urandom, $urandom};
                    end else if (pend[i] && !dir_mask[i]) begin
                        pend[i] = 1'b0;
                    end
                end else begin
                    if (!pend[i] && $urandom_range(0, 99) < 30) begin
                        pend[i]  = 1'b1;
                        pdata[i] = {$urandom, $urandom};
                    end else if (pend[i] && $urandom_range(0, 99) < 4) begin
                        pend[i] = 1'b0;
                    end
                end
                req_valid[i]      = pend[i];
                req_data[i*W +: W] = pend[i] ? pdata[i] : {$urandom, $urandom};
            end
            #1;
            exp_rdy = '0;
            if (!m_out) begin
                for (int k = 0; k < N; k++) begin
                    if (exp_rdy == '0 && req_valid[(m_ptr + k) % N]) exp_rdy[(m_ptr + k) % N] = 1'b1;
                end
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(m_out));
            hs = req_valid & req_ready;
            if (hs != '0) begin
                g = 0;
                for (int k = N - 1; k >= 0; k--) if (hs[k]) g = k;
                pend[g] = 1'b0;
                if (force_d >= 0) d = force_d;
                else begin
                    u = $urandom_range(0, 9);
                    d = (u == 0) ? 0 : (u == 1) ? TO : (u == 2) ? TO + 1 : $urandom_range(1, TO - 1);
                end
                op.opnd = pdata[g];
                op.d    = d;
                op.r    = (force_r >= 0) ? RW'(force_r) : RW'($urandom);
                op.spur = (d >= 1 && d <= TO) && ($urandom_range(0, 1) == 1);
                op.hs   = cyc;
                e.id    = g;
                e.err   = !(d >= 1 && d <= TO);
                e.data  = e.err ? '0 : op.r;
                e.due   = cyc + (e.err ? TO + 2 : d + 2);
                h.g = g;
                h.c = cyc;
                opq.push_back(op);
                expq.push_back(e);
                hs_log.push_back(h);
                m_out = 1'b1;
                hs_count++;
            end
        end
    end

    // Engine model: replies d cycles after init (never when d==0), optional stray done afterwards.
    initial begin : eng_model
        op_t op;
        int  ep;
        eng_done    = 1'b0;
        eng_data_in = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && eng_init) begin
                ep = rst_epoch;
                if (opq.size() == 0) begin
                    expire("eng_init_unexpected");
                    continue;
                end
                op = opq.pop_front();
                chk("eng_operand", eng_data_out, op.opnd);
                chk("eng_init_cycle", 64'(cyc), 64'(op.hs + 1));
                @(negedge clk);
                #1;
                if (ep == rst_epoch) chk("eng_init_single", 64'(eng_init), 64'(0));
                for (int i = 1; i < op.d; i++) begin
                    @(negedge clk);
                    #1;
                    if (ep == rst_epoch) chk("eng_operand_hold", eng_data_out, op.opnd);
                end
                if (op.d > 0) begin
                    eng_done    = 1'b1;
                    eng_data_in = op.r;
                    @(negedge clk);
                    #1;
                    if (op.spur) begin
                        eng_data_in = ~op.r;
                        @(negedge clk);
                        #1;
                    end
                    eng_done    = 1'b0;
                    eng_data_in = RW'($urandom);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response and drives rsp_ready.
    initial begin : rsp_mon
        bit           inr;
        exp_t         cur;
        int           hold;
        logic [N-1:0] rr;
        inr       = 1'b0;
        hold      = 0;
        rsp_ready = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                inr = 1'b0;
                continue;
            end
            if (!inr) begin
                if (rsp_valid != '0) begin
                    if (expq.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                    end else begin
                        cur = expq.pop_front();
                        chk("rsp_valid", 64'(rsp_valid), 64'(1) << cur.id);
                        chk("rsp_data", 64'(rsp_data), 64'(cur.data));
                        chk("rsp_err", 64'(rsp_err), 64'(cur.err));
                        chk("rsp_latency", 64'(cyc), 64'(cur.due));
                        inr  = 1'b1;
                        hold = (cur.id == bp_id) ? bp_len : 0;
                    end
                end
            end else begin
                chk("rsp_valid_hold", 64'(rsp_valid), 64'(1) << cur.id);
                chk("rsp_data_hold", 64'(rsp_data), 64'(cur.data));
                chk("rsp_err_hold", 64'(rsp_err), 64'(cur.err));
            end
            rr = rdy_rand ? N'($urandom) : '1;
            if (inr) begin
                if (hold > 0) begin
                    rr[cur.id] = 1'b0;
                    hold--;
                end else if (rdy_rand) begin
                    rr[cur.id] = ($urandom_range(0, 2) != 0);
                end
                if (rr[cur.id]) begin
                    inr   = 1'b0;
                    m_out = 1'b0;
                    m_ptr = (cur.id + 1) % N;
                end
            end
            rsp_ready = rr;
        end
    end

    task automatic wait_hs(input int target, input int budget, input string name);
        int n = 0;
        while (hs_count < target && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (hs_count < target) expire(name);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((m_out || expq.size() != 0) && n < 400) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (m_out || expq.size() != 0) expire(name);
        repeat (3) @(negedge clk);
        #3;
    endtask

    task automatic one_op(input logic [N-1:0] mask, input int d, input int r, input string name);
        force_d  = d;
        force_r  = r;
        dir_mask = mask;
        wait_hs(hs_count + 1, 100, name);
        dir_mask = '0;
        drain(name);
    endtask

    initial begin : main
        int base;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_data", 64'(rsp_data), 64'(0));
        chk("reset_rsp_err", 64'(rsp_err), 64'(0));
        chk("reset_eng_init", 64'(eng_init), 64'(0));
        chk("reset_eng_data", eng_data_out, 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        use_fixed  = 1'b1;
        fixed_opnd = 64'h100;
        one_op(4'b0001, 1, 8, "single_request");
        use_fixed  = 1'b0;

        base = hs_log.size();
        force_d  = 1;
        force_r  = -1;
        dir_mask = 4'hF;
        wait_hs(hs_count + 8, 200, "round_robin");
        dir_mask = '0;
        drain("round_robin_drain");
        for (int i = base + 1; i < base + 8 && i < hs_log.size(); i++) begin
            chk("rr_spacing", 64'(hs_log[i].c - hs_log[i-1].c), 64'(4));
            chk("rr_order", 64'(hs_log[i].g), 64'((hs_log[i-1].g + 1) % N));
        end

        bp_id    = 2;
        bp_len   = 10;
        dir_mask = 4'hF;
        wait_hs(hs_count + 5, 300, "backpressure");
        dir_mask = '0;
        drain("backpressure_drain");
        bp_id    = -1;

        one_op(4'b0010, 0, -1, "timeout");
        one_op(4'b1000, TO, 5, "done_timeout_collision");
        one_op(4'b0100, TO + 1, 9, "done_after_timeout");

        dir_mode = 1'b0;
        rdy_rand = 1'b1;
        force_d  = -1;
        force_r  = -1;
        wait_hs(hs_count + 150, 20000, "random_traffic");
        dir_mode = 1'b1;
        dir_mask = '0;
        drain("random_drain");
        rdy_rand = 1'b0;

        one_op(4'b0001, 2, -1, "pre_reset_op");
        force_d  = 8;
        dir_mask = 4'b0100;
        wait_hs(hs_count + 1, 100, "reset_mid_wait_req");
        dir_mask = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        rst_epoch++;
        expq.delete();
        opq.delete();
        m_out = 1'b0;
        m_ptr = 0;
        #3;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_rsp_data", 64'(rsp_data), 64'(0));
        chk("midrst_rsp_err", 64'(rsp_err), 64'(0));
        chk("midrst_eng_init", 64'(eng_init), 64'(0));
        chk("midrst_eng_data", eng_data_out, 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #3;
        chk("postrst_busy", 64'(busy), 64'(0));
        chk("postrst_rsp_valid", 64'(rsp_valid), 64'(0));
        force_d  = 1;
        dir_mask = 4'hF;
        wait_hs(hs_count + 1, 50, "postrst_grant");
        dir_mask = '0;
        if (hs_log.size() > 0) chk("postrst_ptr_grant", 64'(hs_log[hs_log.size()-1].g), 64'(0));
        drain("postrst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #(600000);
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ame_num_approx_arb.md
Name: ame_num_approx_arb

Overview:
- Round-robin arbiter/sequencer that shares one 64-bit number-approximation engine among NUM_REQ affine-ME requesters (e.g. per-coefficient shift computation).
- Accepts one request at a time via valid/ready and drives the engine's init/data pins with a one-cycle init pulse.
- Waits for the engine's done, with a timeout guard, and returns the 6-bit result to the granted requester via valid/ready.
- Sits between the AME coefficient-solve stages and the single engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- COMP_DATA_BITS, 64, engine input width.
- TIMEOUT_CYC, 15, max WAIT cycles before an error response (1..255).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept (combinational).
- req_data_i  in  NUM_REQ*COMP_DATA_BITS  request operands; requester i occupies slice [i*W +: W].
- rsp_valid_o  out  NUM_REQ  per-requester response valid (registered).
- rsp_ready_i  in  NUM_REQ  per-requester response accept.
- rsp_data_o  out  $clog2(COMP_DATA_BITS)  shared result bus.
- rsp_err_o  out  1  response is a timeout error.
- eng_init_o  out  1  engine start pulse.
- eng_data_o  out  COMP_DATA_BITS  engine operand (registered).
- eng_done_i  in  1  engine done pulse.
- eng_data_i  in  $clog2(COMP_DATA_BITS)  engine result.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE, ptr 0, gnt_id 0, eng_init_o 0, eng_data_o 0, rsp_valid_o 0, rsp_data_o 0, rsp_err_o 0, timeout counter 0, busy_o 0.
- Reset is asynchronous at any point, including mid-operation. The in-flight request is dropped, and any later eng_done_i is ignored because state is IDLE.
- Grant: the first asserted req_valid_i found searching from ptr upward, wrapping at NUM_REQ-1.
  - req_ready_o[g] = (state==IDLE) && grant one-hot[g]; all other bits are 0.
  - At most one bit of req_ready_o is high; all bits are 0 outside IDLE.
- IDLE: on handshake (valid && ready), latch eng_data_o <= req slice g and gnt_id <= g, then go to ISSUE. Stay in IDLE if no valid.
- ISSUE: eng_init_o=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: eng_data_o is held stable; the counter increments each cycle.
  - eng_done_i=1: rsp_data_o <= eng_data_i, rsp_err_o <= 0, rsp_valid_o[gnt_id] <= 1, go to RESP.
  - Else if counter == TIMEOUT_CYC-1: rsp_data_o <= 0, rsp_err_o <= 1, rsp_valid_o[gnt_id] <= 1, go to RESP.
  - If done and timeout coincide, done wins and rsp_err_o=0.
- RESP: hold rsp_valid_o[gnt_id], rsp_data_o and rsp_err_o stable until rsp_ready_i[gnt_id].
  - On that handshake: rsp_valid_o <= 0, ptr <= (gnt_id+1) mod NUM_REQ, go to IDLE.
  - rsp_ready_i bits of other requesters are ignored.
- eng_done_i outside WAIT is ignored.
- Latency: with a single-cycle engine (done one cycle after init), rsp_valid_o rises 3 cycles after the request handshake cycle. Minimum throughput is one operation per 4 cycles.
- Requesters must hold req_data_i stable while valid and not yet ready. A requester may drop valid before it is granted.
- rsp_err_o is meaningful only while some rsp_valid_o bit is high.

Test Plan:
- Single request: req_valid_i=4'b0001, data 64'h100; engine model returns 6'd8 one cycle after init. Required: ready pulses in cycle 0, eng_init_o high in cycle 1, rsp_valid_o=4'b0001 from cycle 3, rsp_data_o=8, rsp_err_o=0.
- Round-robin: all four valid continuously, rsp_ready_i=4'hF. Required: grant order 0,1,2,3,0, one grant every 4 cycles, eng_init_o never high on consecutive cycles.
- Response backpressure: rsp_ready_i[2]=0 for 10 cycles after rsp_valid_o[2] rises. Required: rsp_data_o and rsp_valid_o held, req_ready_o=0 throughout, next grant goes to requester 3.
- Timeout: engine never asserts done, TIMEOUT_CYC=15. Required: rsp_valid_o set 15 WAIT cycles after ISSUE, rsp_err_o=1, rsp_data_o=0, ptr advances.
- Done/timeout collision: done arrives in the 15th WAIT cycle with eng_data_i=6'd5. Required: rsp_err_o=0, rsp_data_o=5.
- Reset mid-WAIT: rst_n_i low for 1 cycle, then engine done arrives. Required: all outputs at reset values, done ignored, busy_o=0, ptr=0.
